// File: rtl/cpu_pkg.sv
`default_nettype none
// cpu_pkg: shared CPU encodings used by the MEM stage (ALU opcodes, memory
// read/write codes, MEM stage FSM states).
package cpu_pkg;

  localparam logic [3:0] ALU_ADD = 4'h0;
  localparam logic [3:0] ALU_SUB = 4'h1;
  localparam logic [3:0] ALU_AND = 4'h2;
  localparam logic [3:0] ALU_OR  = 4'h3;
  localparam logic [3:0] ALU_XOR = 4'h4;
  localparam logic [3:0] ALU_SLL = 4'h5;
  localparam logic [3:0] ALU_SRL = 4'h6;
  localparam logic [3:0] ALU_SLT = 4'h7;
  localparam logic [3:0] ALU_LW  = 4'h8;
  localparam logic [3:0] ALU_SW  = 4'h9;

  localparam logic [1:0] ROW_NOP   = 2'b00;
  localparam logic [1:0] ROW_READ  = 2'b01;
  localparam logic [1:0] ROW_WRITE = 2'b10;

  typedef enum logic {
    IDLE   = 1'b0,
    ACCESS = 1'b1
  } mem_state_t;

endpackage
`default_nettype wire

// File: rtl/mem_store_buf.sv
`default_nettype none
// mem_store_buf: one-entry posted store buffer draining to data memory with a
// req/ack handshake and ack timeout (instantiated only under MEM_STORE_BUF_EN).
module mem_store_buf #(
  parameter int ACK_TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        push,
  input  logic [31:0] push_addr,
  input  logic [31:0] push_data,
  input  logic        ack,
  output logic        valid,
  output logic [31:0] addr,
  output logic [31:0] data,
  output logic        timeout
);

  localparam int CW = $clog2(ACK_TIMEOUT + 1);

  logic [CW-1:0] cnt;

  // valid doubles as the drain request; it stays high until ack or timeout
  assign timeout = valid && !ack && (cnt == CW'(ACK_TIMEOUT - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid <= 1'b0;
      addr  <= '0;
      data  <= '0;
      cnt   <= '0;
    end else if (push) begin
      valid <= 1'b1;
      addr  <= push_addr;
      data  <= push_data;
      cnt   <= '0;
    end else if (valid) begin
      if (ack || timeout) valid <= 1'b0;
      else                cnt   <= cnt + 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: rtl/mem_stage.sv
`default_nettype none
// mem_stage: MEM pipeline stage - data-memory req/ack access with ack timeout and
// MEM/WB register. Define MEM_STORE_BUF_EN to add a one-entry posted store buffer.
module mem_stage
  import cpu_pkg::*;
#(
  parameter int ACK_TIMEOUT = 255
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic [31:0] addr_i,
  input  logic [31:0] store_data_i,
  input  logic [31:0] IR_i,
  input  logic [1:0]  row_i,
  output logic        stall_o,
  output logic        mem_req_o,
  output logic        mem_we_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wdata_o,
  input  logic        mem_ack_i,
  input  logic [31:0] mem_rdata_i,
  output logic [31:0] wb_data_o,
  output logic [31:0] IR_o,
  output logic        wb_valid_o,
  output logic        err_o
);

  localparam int CW = $clog2(ACK_TIMEOUT + 1);

  mem_state_t    state, state_nx;
  logic [CW-1:0] cnt;
  logic          req_q, we_q;
  logic [31:0]   addr_q, wdata_q, ir_q;
  logic          is_rd, is_wr, buf_en, start, hold, fwd, timeout;
  logic          buf_valid, buf_timeout;
  logic [31:0]   buf_addr, buf_data;

  assign is_rd = (row_i == ROW_READ);
  assign is_wr = (row_i == ROW_WRITE);

`ifdef MEM_STORE_BUF_EN
  assign buf_en = 1'b1;
  mem_store_buf #(.ACK_TIMEOUT(ACK_TIMEOUT)) u_store_buf (
    .clk       (clk_i),
    .rst_n     (rst_ni),
    .push      ((state == IDLE) && is_wr && !buf_valid),
    .push_addr (addr_i),
    .push_data (store_data_i),
    .ack       (mem_ack_i),
    .valid     (buf_valid),
    .addr      (buf_addr),
    .data      (buf_data),
    .timeout   (buf_timeout)
  );
`else
  assign buf_en      = 1'b0;
  assign buf_valid   = 1'b0;
  assign buf_addr    = '0;
  assign buf_data    = '0;
  assign buf_timeout = 1'b0;
`endif

  // Loads hitting the buffered store are forwarded; other memory ops wait for the drain.
  assign fwd     = is_rd && buf_valid && (addr_i == buf_addr);
  assign hold    = (is_rd || is_wr) && buf_valid && !fwd;
  assign start   = (is_rd && !buf_valid) || (is_wr && !buf_en);
  assign timeout = (state == ACCESS) && !mem_ack_i && (cnt == CW'(ACK_TIMEOUT - 1));

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state <= IDLE;
    else         state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:   if (start) state_nx = ACCESS;
      ACCESS: if (mem_ack_i || timeout) state_nx = IDLE;
    endcase
  end

  always_comb begin
    stall_o = 1'b0;
    case (state)
      IDLE:   stall_o = start || hold;
      // release upstream on timeout as well, so the aborted op is not reissued
      ACCESS: stall_o = !mem_ack_i && !timeout;
    endcase
  end

  assign mem_req_o   = req_q || buf_valid;
  assign mem_we_o    = buf_valid || we_q;
  assign mem_addr_o  = buf_valid ? buf_addr : addr_q;
  assign mem_wdata_o = buf_valid ? buf_data : wdata_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      req_q      <= 1'b0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      ir_q       <= '0;
      cnt        <= '0;
      wb_data_o  <= '0;
      IR_o       <= '0;
      wb_valid_o <= 1'b0;
      err_o      <= 1'b0;
    end else begin
      wb_valid_o <= 1'b0;
      if (timeout || buf_timeout) err_o <= 1'b1;
      case (state)
        IDLE: begin
          if (start) begin
            req_q   <= 1'b1;
            we_q    <= is_wr;
            addr_q  <= addr_i;
            wdata_q <= store_data_i;
            ir_q    <= IR_i;
            cnt     <= '0;
          end else if (!hold) begin
            wb_data_o  <= fwd ? buf_data : addr_i;
            IR_o       <= IR_i;
            wb_valid_o <= 1'b1;
          end
        end
        ACCESS: begin
          if (mem_ack_i) begin
            req_q      <= 1'b0;
            wb_data_o  <= we_q ? addr_q : mem_rdata_i;
            IR_o       <= ir_q;
            wb_valid_o <= 1'b1;
          end else if (timeout) begin
            req_q      <= 1'b0;
            wb_data_o  <= '0;
            IR_o       <= ir_q;
            wb_valid_o <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mem_stage.sv
`default_nettype none
// tb_mem_stage: directed self-checking bench for mem_stage built with ACK_TIMEOUT = 4.
module tb_mem_stage;
  import cpu_pkg::*;

  logic        clk = 1'b0;
  logic        rst_ni;
  logic [31:0] addr_i, store_data_i, IR_i;
  logic [1:0]  row_i;
  logic        stall_o, mem_req_o, mem_we_o;
  logic [31:0] mem_addr_o, mem_wdata_o;
  logic        mem_ack_i;
  logic [31:0] mem_rdata_i;
  logic [31:0] wb_data_o, IR_o;
  logic        wb_valid_o, err_o;

  int checks   = 0;
  int failures = 0;
  int stalls;
  int pulses;

  always #5 clk = ~clk;

  mem_stage #(.ACK_TIMEOUT(4)) dut (
    .clk_i        (clk),
    .rst_ni       (rst_ni),
    .addr_i       (addr_i),
    .store_data_i (store_data_i),
    .IR_i         (IR_i),
    .row_i        (row_i),
    .stall_o      (stall_o),
    .mem_req_o    (mem_req_o),
    .mem_we_o     (mem_we_o),
    .mem_addr_o   (mem_addr_o),
    .mem_wdata_o  (mem_wdata_o),
    .mem_ack_i    (mem_ack_i),
    .mem_rdata_i  (mem_rdata_i),
    .wb_data_o    (wb_data_o),
    .IR_o         (IR_o),
    .wb_valid_o   (wb_valid_o),
    .err_o        (err_o)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [1:0] row, input logic [31:0] a, input logic [31:0] d,
                       input logic [31:0] ir);
    row_i        = row;
    addr_i       = a;
    store_data_i = d;
    IR_i         = ir;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst_ni      = 1'b0;
    mem_ack_i   = 1'b0;
    mem_rdata_i = '0;
    drive(ROW_NOP, 32'h0, 32'h0, 32'h0);
    #12;
    check("rst_req",    mem_req_o,  32'd0);
    check("rst_valid",  wb_valid_o, 32'd0);
    check("rst_err",    err_o,      32'd0);
    check("rst_wbdata", wb_data_o,  32'd0);
    check("rst_ir",     IR_o,       32'd0);
    check("rst_maddr",  mem_addr_o, 32'd0);
    check("rst_stall",  stall_o,    32'd0);
    #8 rst_ni = 1'b1;
    step();

    // nop / ALU pass-through, 1-cycle latency
    drive(ROW_NOP, 32'h1234, 32'h0, 32'hA000_0001);
    #1 check("nop_stall", stall_o, 32'd0);
    step();
    check("nop_valid",  wb_valid_o, 32'd1);
    check("nop_wbdata", wb_data_o,  32'h1234);
    check("nop_ir",     IR_o,       32'hA000_0001);

    // illegal code behaves as nop
    drive(2'b11, 32'h5678, 32'h0, 32'hB000_0002);
    #1 check("ill_stall", stall_o, 32'd0);
    step();
    check("ill_wbdata", wb_data_o, 32'h5678);

    // load, ack on 4th ACCESS cycle (also the timeout boundary: ack wins)
    drive(ROW_READ, 32'h40, 32'h0, 32'h8000_0003);
    stalls = 0;
    pulses = 0;
    #1 if (stall_o) stalls++;
    step();
    for (int i = 0; i < 3; i++) begin
      check("lw_req",  mem_req_o,  32'd1);
      check("lw_addr", mem_addr_o, 32'h40);
      check("lw_we",   mem_we_o,   32'd0);
      pulses += int'(wb_valid_o);
      #1 if (stall_o) stalls++;
      step();
    end
    check("lw_req4", mem_req_o, 32'd1);
    pulses += int'(wb_valid_o);
    mem_ack_i   = 1'b1;
    mem_rdata_i = 32'hDEAD_BEEF;
    #1 if (stall_o) stalls++;
    step();
    mem_ack_i = 1'b0;
    drive(ROW_NOP, 32'h0, 32'h0, 32'h0);
    check("lw_req_drop", mem_req_o,  32'd0);
    check("lw_valid",    wb_valid_o, 32'd1);
    check("lw_wbdata",   wb_data_o,  32'hDEAD_BEEF);
    check("lw_ir",       IR_o,       32'h8000_0003);
    check("lw_stalls",   stalls,     32'd4);
    check("lw_bubbles",  pulses,     32'd0);
    check("lw_noerr",    err_o,      32'd0);
    step();

`ifndef MEM_STORE_BUF_EN
    // store, ack in first ACCESS cycle: 2-cycle latency
    drive(ROW_WRITE, 32'h80, 32'h55, 32'h9000_0004);
    #1 check("sw_stall0", stall_o, 32'd1);
    step();
    check("sw_req",   mem_req_o,   32'd1);
    check("sw_we",    mem_we_o,    32'd1);
    check("sw_addr",  mem_addr_o,  32'h80);
    check("sw_wdata", mem_wdata_o, 32'h55);
    check("sw_bubble", wb_valid_o, 32'd0);
    mem_ack_i = 1'b1;
    #1 check("sw_stall1", stall_o, 32'd0);
    step();
    mem_ack_i = 1'b0;
    drive(ROW_NOP, 32'h0, 32'h0, 32'h0);
    check("sw_req_drop", mem_req_o,  32'd0);
    check("sw_valid",    wb_valid_o, 32'd1);
    check("sw_wbdata",   wb_data_o,  32'h80);
    step();
`endif

    // timeout: ack never arrives
    drive(ROW_READ, 32'hC0, 32'h0, 32'h8000_0005);
    step();
    for (int i = 0; i < 4; i++) begin
      check("to_req", mem_req_o, 32'd1);
      step();
    end
    drive(ROW_NOP, 32'h99, 32'h0, 32'hA000_0006);
    check("to_req_drop", mem_req_o,  32'd0);
    check("to_err",      err_o,      32'd1);
    check("to_valid",    wb_valid_o, 32'd1);
    check("to_wbdata",   wb_data_o,  32'd0);
    check("to_ir",       IR_o,       32'h8000_0005);
    step();
    check("to_next",   wb_data_o, 32'h99);
    check("to_sticky", err_o,     32'd1);

    // asynchronous reset in the middle of an access
    drive(ROW_READ, 32'h100, 32'h0, 32'h8000_0007);
    step();
    check("ra_req", mem_req_o, 32'd1);
    #2 rst_ni = 1'b0;
    #1;
    check("ra_req0",    mem_req_o,  32'd0);
    check("ra_err0",    err_o,      32'd0);
    check("ra_wbdata0", wb_data_o,  32'd0);
    check("ra_maddr0",  mem_addr_o, 32'd0);
    check("ra_ir0",     IR_o,       32'd0);
    drive(ROW_NOP, 32'h77, 32'h0, 32'hA000_0008);
    @(negedge clk) rst_ni = 1'b1;
    step();
    check("ra_valid",  wb_valid_o, 32'd1);
    check("ra_wbdata", wb_data_o,  32'h77);
    drive(ROW_READ, 32'h200, 32'h0, 32'h8000_0009);
    step();
    check("ra_lw_addr", mem_addr_o, 32'h200);
    mem_ack_i   = 1'b1;
    mem_rdata_i = 32'hCAFE_F00D;
    step();
    mem_ack_i = 1'b0;
    drive(ROW_NOP, 32'h0, 32'h0, 32'h0);
    check("ra_lw_data", wb_data_o, 32'hCAFE_F00D);
    step();

`ifdef MEM_STORE_BUF_EN
    // posted store followed by a forwarded load to the same address
    drive(ROW_WRITE, 32'h80, 32'h7, 32'h9000_000A);
    #1 check("sb_sw_stall", stall_o, 32'd0);
    step();
    check("sb_sw_valid",  wb_valid_o,  32'd1);
    check("sb_sw_wbdata", wb_data_o,   32'h80);
    check("sb_drain_req", mem_req_o,   32'd1);
    check("sb_drain_we",  mem_we_o,    32'd1);
    check("sb_drain_wd",  mem_wdata_o, 32'h7);
    drive(ROW_READ, 32'h80, 32'h0, 32'h8000_000B);
    #1 check("sb_lw_stall", stall_o, 32'd0);
    mem_ack_i = 1'b1;
    step();
    mem_ack_i = 1'b0;
    drive(ROW_NOP, 32'h0, 32'h0, 32'h0);
    check("sb_lw_valid",  wb_valid_o, 32'd1);
    check("sb_lw_wbdata", wb_data_o,  32'h7);
    check("sb_no_read",   mem_req_o,  32'd0);
    step();
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
